// File: rtl/stereo_gain_stage.sv
// Mono-to-stereo gain stage: per-channel Q1.7 gain with saturation,
// then a soft mute/unmute ramp, emitted as packed {left, right} words.
module stereo_gain_stage #(
    parameter int SAMPLE_W  = 24,
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 16
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic [SAMPLE_W-1:0]     in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [GAIN_W-1:0]       gain_l,
    input  logic [GAIN_W-1:0]       gain_r,
    input  logic                    mute,
    output logic [2*SAMPLE_W-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    muted
);

    localparam int ATT_W = 8;
    localparam int P_W   = SAMPLE_W + GAIN_W + 1;
    localparam int Q_W   = SAMPLE_W + ATT_W + 1;

    localparam logic [ATT_W-1:0] ATT_FULL = 8'd128;
    localparam logic [ATT_W:0]   STEP_EXT = RAMP_STEP[ATT_W:0];

    typedef enum logic [1:0] {
        ST_MUTED     = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } ramp_e;

    function automatic logic [SAMPLE_W-1:0] sat(
        input logic signed [P_W-1:0] v
    );
        logic [SAMPLE_W-1:0] r;
        if (&v[P_W-1:SAMPLE_W-1] || ~|v[P_W-1:SAMPLE_W-1]) begin
            r = v[SAMPLE_W-1:0];
        end else if (v[P_W-1]) begin
            r = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end else begin
            r = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
        return r;
    endfunction

    function automatic logic [SAMPLE_W-1:0] scale_gain(
        input logic [SAMPLE_W-1:0] s,
        input logic [GAIN_W-1:0]   g
    );
        logic signed [P_W-1:0] a;
        logic signed [P_W-1:0] b;
        logic signed [P_W-1:0] p;
        a = {{(P_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
        b = {{(P_W-GAIN_W){1'b0}}, g};
        p = (a * b) >>> 7;
        return sat(p);
    endfunction

    // att never exceeds 128, so the shifted product always fits
    function automatic logic [SAMPLE_W-1:0] scale_att(
        input logic [SAMPLE_W-1:0] s,
        input logic [ATT_W-1:0]    att
    );
        logic signed [Q_W-1:0] a;
        logic signed [Q_W-1:0] b;
        a = {{(Q_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
        b = {{(Q_W-ATT_W){1'b0}}, att};
        return SAMPLE_W'((a * b) >>> 7);
    endfunction

    ramp_e                 state_q, state_d;
    logic [ATT_W-1:0]      att_q, att_d;

    logic                  s1_valid_q, s1_valid_d;
    logic [SAMPLE_W-1:0]   s1_l_q, s1_l_d;
    logic [SAMPLE_W-1:0]   s1_r_q, s1_r_d;
    logic [ATT_W-1:0]      s1_att_q, s1_att_d;

    logic                  out_valid_q, out_valid_d;
    logic [2*SAMPLE_W-1:0] out_data_q, out_data_d;

    logic                  stall;
    logic                  in_acc;
    logic [ATT_W:0]        att_up_w;
    logic [ATT_W-1:0]      att_up;
    logic [ATT_W-1:0]      att_dn;

    always_comb begin
        stall    = out_valid_q && !out_ready;
        in_ready = !stall;
        in_acc   = in_valid && !stall;
    end

    always_comb begin
        att_up_w = {1'b0, att_q} + STEP_EXT;
        if (att_up_w >= {1'b0, ATT_FULL}) begin
            att_up = ATT_FULL;
        end else begin
            att_up = att_up_w[ATT_W-1:0];
        end
        if ({1'b0, att_q} <= STEP_EXT) begin
            att_dn = '0;
        end else begin
            att_dn = att_q - STEP_EXT[ATT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_MUTED;
            att_q   <= '0;
        end else begin
            state_q <= state_d;
            att_q   <= att_d;
        end
    end

    // Ramp only moves on accepted samples; reversal takes effect at once
    always_comb begin
        state_d = state_q;
        att_d   = att_q;
        if (in_acc) begin
            unique case (state_q)
                ST_RUN: begin
                    if (mute) begin
                        att_d   = att_dn;
                        state_d = (att_dn == '0) ? ST_MUTED : ST_RAMP_DOWN;
                    end
                end
                ST_MUTED: begin
                    if (!mute) begin
                        att_d   = att_up;
                        state_d = (att_up == ATT_FULL) ? ST_RUN : ST_RAMP_UP;
                    end
                end
                ST_RAMP_DOWN, ST_RAMP_UP: begin
                    if (mute) begin
                        att_d   = att_dn;
                        state_d = (att_dn == '0) ? ST_MUTED : ST_RAMP_DOWN;
                    end else begin
                        att_d   = att_up;
                        state_d = (att_up == ATT_FULL) ? ST_RUN : ST_RAMP_UP;
                    end
                end
                default: begin
                    att_d   = '0;
                    state_d = ST_MUTED;
                end
            endcase
        end
    end

    always_comb begin
        muted = (state_q == ST_MUTED);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_l_d     = s1_l_q;
        s1_r_d     = s1_r_q;
        s1_att_d   = s1_att_q;
        if (!stall) begin
            s1_valid_d = in_valid;
        end
        if (in_acc) begin
            s1_l_d   = scale_gain(in_data, gain_l);
            s1_r_d   = scale_gain(in_data, gain_r);
            s1_att_d = att_q;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (!stall) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = {scale_att(s1_l_q, s1_att_q),
                              scale_att(s1_r_q, s1_att_q)};
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_valid_q  <= 1'b0;
            s1_l_q      <= '0;
            s1_r_q      <= '0;
            s1_att_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_l_q      <= s1_l_d;
            s1_r_q      <= s1_r_d;
            s1_att_q    <= s1_att_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_stereo_gain_stage.sv
// Bench for stereo_gain_stage: directed steps plus random traffic,
// scored against an arithmetic model of gain, saturation and ramp.
module tb_stereo_gain_stage;

    localparam int STEP = 16;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  gain_l;
    logic [7:0]  gain_r;
    logic        mute;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        muted;

    always #5 clk = ~clk;

    stereo_gain_stage #(
        .SAMPLE_W (24),
        .GAIN_W   (8),
        .RAMP_STEP(STEP)
    ) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .gain_l   (gain_l),
        .gain_r   (gain_r),
        .mute     (mute),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .muted    (muted)
    );

    int          checks = 0;
    int          errors = 0;
    longint      att_m;
    logic [47:0] exp_q[$];
    logic [47:0] obs[$];
    bit          last_in_acc;
    bit          prev_stall;
    logic [47:0] prev_data;

    task automatic chk(input string tag, input logic [47:0] got,
                       input logic [47:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint fdiv128(longint x);
        longint q;
        q = x / 128;
        if ((x % 128) != 0 && x < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [23:0] chan(logic [23:0] d, logic [7:0] g,
                                         longint a);
        longint p;
        p = fdiv128(longint'($signed(d)) * longint'(g));
        if (p > 8388607) p = 8388607;
        if (p < -8388608) p = -8388608;
        p = fdiv128(p * a);
        return p[23:0];
    endfunction

    task automatic model_accept(input logic [23:0] d);
        exp_q.push_back({chan(d, gain_l, att_m), chan(d, gain_r, att_m)});
        if (mute) att_m = (att_m > STEP) ? att_m - STEP : 0;
        else att_m = (att_m + STEP > 128) ? 128 : att_m + STEP;
    endtask

    // Called at a falling edge; one clock of traffic with full scoring
    task automatic step(input bit iv, input logic [23:0] d, input bit ordy);
        logic [47:0] e;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        chk("in_ready", 48'(in_ready), 48'(!(out_valid && !out_ready)));
        if (prev_stall) begin
            chk("hold_valid", 48'(out_valid), 48'(1));
            chk("hold_data", out_data, prev_data);
        end
        prev_stall  = out_valid && !out_ready;
        prev_data   = out_data;
        last_in_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 48'(out_valid), 48'(0));
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e);
                obs.push_back(out_data);
            end
        end
        if (last_in_acc) model_accept(d);
        @(posedge clk);
        #1;
        chk("muted", 48'(muted), 48'(att_m == 0));
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            step(1'b0, 24'h0, 1'b1);
            n++;
        end
        chk("drain_left", 48'(exp_q.size()), 48'(0));
        chk("drain_idle", 48'(out_valid), 48'(0));
    endtask

    initial begin
        int idx;
        int k;
        logic [23:0] v;
        logic [47:0] tbl[7];

        arst_n    = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        mute      = 1'b0;
        gain_l    = 8'd128;
        gain_r    = 8'd128;
        att_m     = 0;
        prev_stall = 1'b0;
        #2 arst_n = 1'b0;
        #1;
        chk("rst_out_valid", 48'(out_valid), 48'(0));
        chk("rst_out_data", out_data, 48'h0);
        chk("rst_in_ready", 48'(in_ready), 48'(1));
        chk("rst_muted", 48'(muted), 48'(1));
        repeat (2) @(negedge clk);
        arst_n = 1'b1;

        // Soft start from silence
        obs.delete();
        for (int i = 0; i < 9; i++) step(1'b1, 24'h100000, 1'b1);
        drain();
        chk("soft_cnt", 48'(obs.size()), 48'(9));
        if (obs.size() == 9) begin
            chk("soft_0", obs[0], 48'h000000_000000);
            chk("soft_1", obs[1], 48'h020000_020000);
            chk("soft_2", obs[2], 48'h040000_040000);
            chk("soft_8", obs[8], 48'h100000_100000);
        end

        // Saturation and sign handling
        gain_l = 8'd255;
        gain_r = 8'd64;
        obs.delete();
        step(1'b1, 24'h7FFFFF, 1'b1);
        step(1'b1, 24'h800000, 1'b1);
        step(1'b1, 24'hFFFFFD, 1'b1);
        drain();
        chk("sat_cnt", 48'(obs.size()), 48'(3));
        if (obs.size() == 3) begin
            chk("sat_pos", obs[0], 48'h7FFFFF_3FFFFF);
            chk("sat_neg", obs[1], 48'h800000_C00000);
            chk("sat_small", obs[2], 48'hFFFFFA_FFFFFE);
        end

        // Random backpressure on an in-order ramp
        gain_l = 8'd128;
        gain_r = 8'd128;
        obs.delete();
        idx = 1;
        k = 0;
        while (idx <= 20 && k < 2000) begin
            step(1'($urandom % 2), 24'(idx), 1'($urandom % 2));
            if (last_in_acc) idx++;
            k++;
        end
        chk("bp_sent", 48'(idx), 48'(21));
        drain();
        chk("bp_cnt", 48'(obs.size()), 48'(20));
        for (int i = 0; i < 20; i++) begin
            if (i < obs.size()) begin
                v = 24'(i + 1);
                chk("bp_order", obs[i], {v, v});
            end
        end

        // Mute for three accepts, then reverse
        obs.delete();
        mute = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 24'h100000, 1'b1);
        mute = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 24'h100000, 1'b1);
        drain();
        tbl = '{48'h100000_100000, 48'h0E0000_0E0000, 48'h0C0000_0C0000,
                48'h0A0000_0A0000, 48'h0C0000_0C0000, 48'h0E0000_0E0000,
                48'h100000_100000};
        chk("rev_cnt", 48'(obs.size()), 48'(7));
        for (int i = 0; i < 7; i++) begin
            if (i < obs.size()) chk("rev_att", obs[i], tbl[i]);
        end

        // Full mute: silence for any input and gain afterwards
        obs.delete();
        mute = 1'b1;
        for (int i = 0; i < 9; i++) step(1'b1, 24'($urandom), 1'b1);
        chk("full_muted", 48'(muted), 48'(1));
        for (int i = 0; i < 4; i++) begin
            gain_l = 8'($urandom);
            gain_r = 8'($urandom);
            step(1'b1, 24'($urandom), 1'b1);
        end
        drain();
        chk("full_cnt", 48'(obs.size()), 48'(13));
        for (int i = 8; i < 13; i++) begin
            if (i < obs.size()) chk("full_zero", obs[i], 48'h0);
        end

        // Random traffic, gains and mute toggling
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 8 == 0) mute = ~mute;
            if ($urandom % 16 == 0) begin
                gain_l = 8'($urandom);
                gain_r = 8'($urandom);
            end
            step(1'($urandom % 4 != 0), 24'($urandom), 1'($urandom % 4 != 0));
        end
        drain();

        // Asynchronous reset with two samples in flight
        mute   = 1'b0;
        gain_l = 8'd128;
        gain_r = 8'd128;
        step(1'b1, 24'h123456, 1'b1);
        step(1'b1, 24'h234567, 1'b1);
        chk("pre_rst_valid", 48'(out_valid), 48'(1));
        in_valid = 1'b0;
        arst_n   = 1'b0;
        #1;
        chk("arst_valid", 48'(out_valid), 48'(0));
        chk("arst_muted", 48'(muted), 48'(1));
        chk("arst_data", out_data, 48'h0);
        exp_q.delete();
        att_m      = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        chk("arst_hold", 48'(out_valid), 48'(0));
        @(negedge clk);
        arst_n = 1'b1;
        obs.delete();
        step(1'b1, 24'h400000, 1'b1);
        drain();
        chk("post_rst_cnt", 48'(obs.size()), 48'(1));
        if (obs.size() == 1) chk("post_rst_zero", obs[0], 48'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stereo_gain_stage.md
Name: stereo_gain_stage

Overview:
- Streaming audio stage between the mono sine generator and the 48-bit sample FIFO that feeds the I2S master.
- Takes 24-bit signed mono samples and applies independent left/right gain with saturation.
- Applies a click-free soft mute/unmute ramp.
- Emits packed {left, right} 48-bit stereo words using the same valid/ready handshake as its neighbours.

Parameters:
- SAMPLE_W, 24, signed sample width per channel.
- GAIN_W, 8, unsigned gain width, Q1.7 format (128 = unity, 255 ≈ 1.99).
- RAMP_STEP, 16, attenuation increment/decrement per accepted input sample (1..128).

Ports:
- clk  in  1  system clock.
- arst_n  in  1  asynchronous active-low reset.
- in_data  in  SAMPLE_W  signed mono sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  stage can accept a sample.
- gain_l  in  GAIN_W  left gain, Q1.7.
- gain_r  in  GAIN_W  right gain, Q1.7.
- mute  in  1  level: 1 requests ramp to silence, 0 requests ramp to full level.
- out_data  out  2*SAMPLE_W  {left[47:24], right[23:0]}.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream (FIFO not full) accepts.
- muted  out  1  high while ramp state is MUTED.

Behaviour:
- Reset is asynchronous and active-low, on arst_n. While reset is asserted:
  - out_valid = 0, out_data = 0.
  - Both pipeline valid bits cleared.
  - Ramp state = MUTED, att = 0, muted = 1.
  - in_ready = 1.
- Handshake:
  - A transfer occurs on a cycle where valid && ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational); the whole pipeline holds when stalled.
  - out_data is stable while out_valid && !out_ready.
  - No sample is dropped or duplicated.
- Pipeline: 2 register stages, latency 2 cycles from accept to out_valid when not stalled. Full throughput is 1 sample/cycle.
- Stage 1, on accept:
  - p = in_data * gain (gain zero-extended, signed product), then arithmetic shift right by 7 (floor).
  - Saturate to SAMPLE_W: clamp to 0x7FFFFF / 0x800000. Done per channel.
  - att is captured alongside the sample.
- Stage 2:
  - q = s1 * att, arithmetic shift right by 7 (floor).
  - att ≤ 128, so no saturation is needed.
  - Result registered into out_data.
- Gains are sampled only on accept. Changing gains mid-stream affects subsequent samples only.
- att (0..128) and the ramp state advance once per accepted input sample. The accepted sample uses the pre-update att.
- Ramp FSM, evaluated on each accept:
  - RUN (att = 128): mute = 1 -> RAMP_DOWN.
  - RAMP_DOWN: att = max(att - RAMP_STEP, 0).
    - Reaching 0 -> MUTED.
    - mute = 0 -> RAMP_UP from current att (reversal applies this accept).
  - MUTED (att = 0): mute = 0 -> RAMP_UP.
  - RAMP_UP: att = min(att + RAMP_STEP, 128).
    - Reaching 128 -> RUN.
    - mute = 1 -> RAMP_DOWN from current att.
- No accept means no ramp progress, regardless of mute toggling.
- Simultaneous in accept and out accept while the pipeline is full: allowed, and throughput is kept.
- Reset mid-stream: in-flight samples are discarded and no out_valid is seen. After release, the ramp restarts from MUTED/att = 0 (soft start).

Test Plan:
- Soft start:
  - Stimulus: reset, mute = 0, gain_l = gain_r = 128, RAMP_STEP = 16, constant in_data = 0x100000.
  - Required: outputs per channel 0x000000, 0x020000, 0x040000 … 0x100000 on sample 9 onward; muted drops after the first accept.
- Saturation/sign:
  - Stimulus: in RUN, gain_l = 255, gain_r = 64; in_data = 0x7FFFFF, then 0x800000, then 0xFFFFFD.
  - Required left: 0x7FFFFF, 0x800000, 0xFFFFFD*255>>7 = 0xFFFFFA (-6).
  - Required right: 0x3FFFFF, 0xC00000, 0xFFFFFE (-192>>7 = -2).
- Backpressure:
  - Stimulus: in RUN, stream a ramp 1..20 with out_ready toggling randomly and in_valid randomly.
  - Required: an exact in-order output sequence, no loss or duplication, out_data stable while stalled, in_ready low exactly when out_valid && !out_ready.
- Mute ramp and reversal:
  - Stimulus: in RUN, assert mute for 3 accepts, then deassert.
  - Required: att sequence per sample 128, 112, 96, 80, 96, 112, 128; muted never asserts.
- Full mute:
  - Stimulus: hold mute through 9 accepts.
  - Required: muted = 1 after att reaches 0; subsequent outputs are 0 for any input and gain.
- Async reset mid-stream:
  - Stimulus: assert arst_n low with 2 samples in flight.
  - Required: out_valid = 0 immediately (no clock edge needed), muted = 1; after release the first output equals 0 (att = 0).
